// File: rtl/rectangle_pkg.sv
// Shared definitions for the RECTANGLE-80 key schedule.
//   KEY_W / RK_W : master key and round key widths
//   RC_INIT      : round-constant LFSR seed
//   SBOX         : 4-bit S-box used on the key-state columns
//   state_e      : schedule FSM states
//   rc_next      : one step of the 5-bit round-constant LFSR
package rectangle_pkg;

  localparam int unsigned KEY_W = 80;
  localparam int unsigned RK_W  = 64;

  localparam logic [4:0] RC_INIT = 5'h01;

  localparam logic [3:0] SBOX [16] = '{
    4'h6, 4'h5, 4'hC, 4'hA, 4'h1, 4'hE, 4'h7, 4'h9,
    4'hB, 4'h0, 4'h3, 4'hD, 4'h8, 4'hF, 4'h4, 4'h2
  };

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  function automatic logic [4:0] rc_next(input logic [4:0] rc);
    return {rc[3:0], rc[4] ^ rc[2]};
  endfunction

endpackage

// File: rtl/rectangle_key_schedule_if.sv
// Key-schedule handshake bundle.
//   start, key_in      : launch a run with an 80-bit master key
//   round_key, rk_valid: presented round key, rk_ready accepts it
//   busy, done         : run in progress / one-cycle completion pulse
//   rk_index           : index of the presented key (only with RECTANGLE_KS_INDEX_EN)
// Modport master is the key schedule; slave is the round datapath side.
interface rectangle_key_schedule_if;
  import rectangle_pkg::*;

  logic             start;
  logic [KEY_W-1:0] key_in;
  logic [RK_W-1:0]  round_key;
  logic             rk_valid;
  logic             rk_ready;
  logic             busy;
  logic             done;
`ifdef RECTANGLE_KS_INDEX_EN
  logic [4:0]       rk_index;
`endif

  modport master (
    input  start,
    input  key_in,
    input  rk_ready,
    output round_key,
    output rk_valid,
    output busy,
`ifdef RECTANGLE_KS_INDEX_EN
    output rk_index,
`endif
    output done
  );

  modport slave (
    output start,
    output key_in,
    output rk_ready,
    input  round_key,
    input  rk_valid,
    input  busy,
`ifdef RECTANGLE_KS_INDEX_EN
    input  rk_index,
`endif
    input  done
  );

endinterface

// File: rtl/rectangle_sbox4.sv
// RECTANGLE 4-bit S-box, purely combinational.
//   a : input nibble
//   y : substituted nibble
module rectangle_sbox4
  import rectangle_pkg::*;
(
  input  logic [3:0] a,
  output logic [3:0] y
);

  assign y = SBOX[a];

endmodule

// File: rtl/rectangle_key_schedule.sv
// Iterative RECTANGLE-80 key schedule. Expands an 80-bit master key into NUM_RK
// 64-bit round keys, one per accepted handshake.
//   clk, rst : clock, synchronous active-high reset
//   bus      : master modport (start/key_in in, round_key/rk_valid out, rk_ready in,
//              busy/done out, rk_index out when RECTANGLE_KS_INDEX_EN is defined)
// NUM_RK must lie in 2..31.
// Optional feature macro: RECTANGLE_KS_INDEX_EN exposes the key counter as rk_index.
module rectangle_key_schedule
  import rectangle_pkg::*;
#(
  parameter int unsigned NUM_RK = 26
) (
  input logic                      clk,
  input logic                      rst,
  rectangle_key_schedule_if.master bus
);

  localparam logic [4:0] LastIdx = 5'(NUM_RK - 1);

  state_e           state_q, state_d;
  logic [4:0][15:0] row_q, row_d;
  logic [4:0]       rc_q, rc_d;
  logic [4:0]       cnt_q, cnt_d;

  // Key state after the column S-box and after the full update.
  logic [3:0][15:0] row_s;
  logic [4:0][15:0] row_upd;
  logic [3:0]       col_in  [4];
  logic [3:0]       col_out [4];

  // Column j nibble is {Row3[j],Row2[j],Row1[j],Row0[j]}; only columns 0..3 are substituted.
  for (genvar j = 0; j < 4; j++) begin : g_col
    assign col_in[j] = {row_q[3][j], row_q[2][j], row_q[1][j], row_q[0][j]};
    rectangle_sbox4 u_sbox (
      .a (col_in[j]),
      .y (col_out[j])
    );
  end

  for (genvar r = 0; r < 4; r++) begin : g_row
    assign row_s[r] = {row_q[r][15:4], col_out[3][r], col_out[2][r], col_out[1][r],
                       col_out[0][r]};
  end

  always_comb begin
    row_upd    = '0;
    row_upd[0] = {row_s[0][7:0], row_s[0][15:8]} ^ row_s[1] ^ {11'd0, rc_q};
    row_upd[1] = row_s[2];
    row_upd[2] = row_s[3];
    row_upd[3] = {row_s[3][3:0], row_s[3][15:4]} ^ row_q[4];
    row_upd[4] = row_s[0];
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    rc_d    = rc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StRun;
          row_d   = bus.key_in;
          rc_d    = RC_INIT;
          cnt_d   = '0;
        end
      end
      StRun: begin
        if (bus.rk_ready) begin
          cnt_d = cnt_q + 5'd1;
          // The final key is consumed without advancing the key state.
          if (cnt_q == LastIdx) begin
            state_d = StDone;
          end else begin
            row_d = row_upd;
            rc_d  = rc_next(rc_q);
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      row_q   <= '0;
      rc_q    <= RC_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      rc_q    <= rc_d;
      cnt_q   <= cnt_d;
    end
  end

  // All outputs decode registered state only, so rk_ready never reaches them combinationally.
  assign bus.round_key = row_q[3:0];
  assign bus.rk_valid  = (state_q == StRun);
  assign bus.busy      = (state_q != StIdle);
  assign bus.done      = (state_q == StDone);
`ifdef RECTANGLE_KS_INDEX_EN
  assign bus.rk_index  = cnt_q;
`endif

endmodule

// File: tb/tb_rectangle_key_schedule.sv
// Self-checking bench for rectangle_key_schedule: a behavioural expansion model plus
// per-cycle compare process on a NUM_RK=26 instance, and directed checks on NUM_RK=2.
module tb_rectangle_key_schedule;

  logic clk;
  logic rst;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  rectangle_key_schedule_if ifm ();
  rectangle_key_schedule_if if2 ();

  rectangle_key_schedule #(.NUM_RK(26)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (ifm)
  );

  rectangle_key_schedule #(.NUM_RK(2)) u_dut2 (
    .clk (clk),
    .rst (rst),
    .bus (if2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int          sb [16] = '{6, 5, 12, 10, 1, 14, 7, 9, 11, 0, 3, 13, 8, 15, 4, 2};
  logic [63:0] exp_keys [32];
  logic [4:0]  exp_rc [32];

  function automatic logic [15:0] rotl(input logic [15:0] x, input int s);
    return (x << s) | (x >> (16 - s));
  endfunction

  task automatic gen_keys(input logic [79:0] key, input int n);
    logic [15:0] r [5];
    logic [15:0] t [5];
    logic [4:0]  rc;
    int          v;
    for (int k = 0; k < 5; k++) r[k] = key[16*k +: 16];
    rc = 5'h01;
    for (int i = 0; i < n; i++) begin
      exp_keys[i] = {r[3], r[2], r[1], r[0]};
      exp_rc[i]   = rc;
      for (int c = 0; c < 4; c++) begin
        v = 8 * int'(r[3][c]) + 4 * int'(r[2][c]) + 2 * int'(r[1][c]) + int'(r[0][c]);
        v = sb[v];
        for (int b = 0; b < 4; b++) r[b][c] = ((v >> b) & 1) != 0;
      end
      t[0] = rotl(r[0], 8) ^ r[1] ^ {11'd0, rc};
      t[1] = r[2];
      t[2] = r[3];
      t[3] = rotl(r[3], 12) ^ r[4];
      t[4] = r[0];
      r    = t;
      rc   = {rc[3:0], rc[4] ^ rc[2]};
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    tot_cnt++;
    if (act === want) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", nm, act, want);
  endtask

  function automatic logic [79:0] rand80();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[79:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // ---------------- compare process ----------------
  // m_phase: 0 idle, 1 presenting key m_idx, 2 done pulse. Describes what the DUT should
  // show during the current cycle; updated at negedge for the next rising edge.
  bit mon_en = 1'b0;
  int m_phase = 0;
  int m_idx = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      chk("busy", 64'(ifm.busy), 64'(m_phase != 0));
      chk("rk_valid", 64'(ifm.rk_valid), 64'(m_phase == 1));
      chk("done", 64'(ifm.done), 64'(m_phase == 2));
      if (m_phase == 1) begin
        chk($sformatf("round_key[%0d]", m_idx), ifm.round_key, exp_keys[m_idx]);
`ifdef RECTANGLE_KS_INDEX_EN
        chk("rk_index", 64'(ifm.rk_index), 64'(m_idx));
`endif
      end
    end
    if (rst) begin
      m_phase = 0;
    end else begin
      case (m_phase)
        0: if (ifm.start) begin
          gen_keys(ifm.key_in, 26);
          m_phase = 1;
          m_idx   = 0;
        end
        1: if (ifm.rk_ready) begin
          if (m_idx == 25) m_phase = 2;
          else m_idx++;
        end
        default: m_phase = 0;
      endcase
    end
  end

  // ---------------- stimulus ----------------
  task automatic run_key(input logic [79:0] key, input bit rnd, input bit mid_start);
    int  vcnt;
    int  dcnt;
    bit  fin;
    ifm.key_in   = key;
    ifm.start    = 1'b1;
    ifm.rk_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    step();
    ifm.start  = 1'b0;
    ifm.key_in = rand80();
    vcnt = 0;
    dcnt = 0;
    fin  = 1'b0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (ifm.rk_valid) vcnt++;
      if (ifm.done) dcnt++;
      if (dcnt > 0 && !ifm.busy) begin
        fin = 1'b1;
        break;
      end
      if (mid_start && cyc == 7) begin
        ifm.start  = 1'b1;
        ifm.key_in = rand80();
      end else begin
        ifm.start = 1'b0;
      end
      ifm.rk_ready = rnd ? 1'($urandom_range(0, 3) != 0) : 1'b1;
      step();
    end
    ifm.start = 1'b0;
    chk("run_finished", 64'(fin), 64'd1);
    chk("done_pulses", 64'(dcnt), 64'd1);
    if (!rnd) chk("valid_cycles", 64'(vcnt), 64'd26);
  endtask

  logic [79:0] k2;
  logic [63:0] k2_1;

  initial begin
    rst          = 1'b1;
    ifm.start    = 1'b0;
    ifm.key_in   = '0;
    ifm.rk_ready = 1'b0;
    if2.start    = 1'b0;
    if2.key_in   = '0;
    if2.rk_ready = 1'b0;

    // Pin the model with hand-computed values.
    gen_keys(80'h0, 26);
    chk("model_zero_k0", exp_keys[0], 64'h0);
    chk("model_zero_k1", exp_keys[1], 64'h0000_0000_000F_000E);
    chk("model_rc0", 64'(exp_rc[0]), 64'h01);
    chk("model_rc1", 64'(exp_rc[1]), 64'h02);
    chk("model_rc2", 64'(exp_rc[2]), 64'h04);
    chk("model_rc3", 64'(exp_rc[3]), 64'h09);
    chk("model_rc4", 64'(exp_rc[4]), 64'h12);
    gen_keys(80'hFFFF_FFFF_FFFF_FFFF_FFFF, 26);
    chk("model_ones_k0", exp_keys[0], 64'hFFFF_FFFF_FFFF_FFFF);
    chk("model_ones_k1", exp_keys[1], 64'hF000_FFF0_FFF0_0F01);

    repeat (3) step();
    chk("reset_round_key", ifm.round_key, 64'h0);
    chk("reset_rk_valid", 64'(ifm.rk_valid), 64'd0);
    chk("reset_busy", 64'(ifm.busy), 64'd0);
    chk("reset_done", 64'(ifm.done), 64'd0);
`ifdef RECTANGLE_KS_INDEX_EN
    chk("reset_rk_index", 64'(ifm.rk_index), 64'd0);
`endif
    rst    = 1'b0;
    step();
    mon_en = 1'b1;

    // Zero key, consumer always ready.
    run_key(80'h0, 1'b0, 1'b0);
    step();
    // All-ones key, always ready.
    run_key(80'hFFFF_FFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    // Random keys with random back-pressure.
    for (int i = 0; i < 3; i++) run_key(rand80(), 1'b1, 1'b0);
    // Mid-run start with another key must be ignored.
    run_key(rand80(), 1'b1, 1'b1);
    run_key(rand80(), 1'b0, 1'b1);

    // Reset while K10 is presented.
    ifm.key_in   = rand80();
    ifm.start    = 1'b1;
    ifm.rk_ready = 1'b1;
    step();
    ifm.start = 1'b0;
    for (int cyc = 0; cyc < 50; cyc++) begin
      if (m_phase == 1 && m_idx == 10) break;
      step();
    end
    chk("reached_k10", 64'(m_phase == 1 && m_idx == 10), 64'd1);
    rst       = 1'b1;
    ifm.start = 1'b1;
    step();
    ifm.start = 1'b0;
    rst       = 1'b0;
    chk("rst_run_valid", 64'(ifm.rk_valid), 64'd0);
    chk("rst_run_busy", 64'(ifm.busy), 64'd0);
    chk("rst_run_done", 64'(ifm.done), 64'd0);
    chk("rst_run_key", ifm.round_key, 64'h0);
    step();
    run_key(rand80(), 1'b1, 1'b0);

    // NUM_RK = 2 instance, directed.
    mon_en = 1'b0;
    k2 = rand80();
    gen_keys(k2, 2);
    k2_1         = exp_keys[1];
    if2.key_in   = k2;
    if2.start    = 1'b1;
    if2.rk_ready = 1'b1;
    step();
    if2.start  = 1'b0;
    if2.key_in = rand80();
    chk("n2_k0_valid", 64'(if2.rk_valid), 64'd1);
    chk("n2_k0", if2.round_key, k2[63:0]);
`ifdef RECTANGLE_KS_INDEX_EN
    chk("n2_idx0", 64'(if2.rk_index), 64'd0);
`endif
    step();
    chk("n2_k1_valid", 64'(if2.rk_valid), 64'd1);
    chk("n2_k1", if2.round_key, k2_1);
`ifdef RECTANGLE_KS_INDEX_EN
    chk("n2_idx1", 64'(if2.rk_index), 64'd1);
`endif
    step();
    chk("n2_done", 64'(if2.done), 64'd1);
    chk("n2_done_busy", 64'(if2.busy), 64'd1);
    chk("n2_done_valid", 64'(if2.rk_valid), 64'd0);
    step();
    chk("n2_idle_busy", 64'(if2.busy), 64'd0);
    chk("n2_idle_done", 64'(if2.done), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/rectangle_key_schedule.md
# rectangle_key_schedule

Iterative RECTANGLE-80 key schedule that expands an 80-bit master key into the 26 64-bit round keys consumed by the round datapath (AddRoundKey followed by SubColumn). It sits directly upstream of that datapath and drives its `round_key` input. Keys are delivered one per accepted handshake, and the schedule state advances only when the consumer takes a key.

## Interface
- `NUM_RK`, default 26: round keys emitted per run (25 rounds plus the final whitening key); legal range 2..31.
- `clk  input  1`: single clock, rising edge.
- `rst  input  1`: synchronous, active-high reset.
- `start  input  1`: launch a schedule run; sampled only while `busy`=0.
- `key_in  input  80`: master key, sampled on the start cycle; `[15:0]`=Row0, `[31:16]`=Row1, `[47:32]`=Row2, `[63:48]`=Row3, `[79:64]`=Row4.
- `round_key  output  64`: current round key `{Row3,Row2,Row1,Row0}`; registered.
- `rk_valid  output  1`: `round_key` is valid.
- `rk_ready  input  1`: consumer accepts `round_key` this cycle.
- `busy  output  1`: a run is in progress.
- `done  output  1`: one-cycle pulse after the last key is accepted.
- `rk_index  output  5`: index of the presented key, 0..`NUM_RK`-1. Present only with `RECTANGLE_KS_INDEX_EN`.

## Operation
- FSM states:
  - IDLE: `busy`=0, `rk_valid`=0.
  - RUN: `busy`=1, `rk_valid`=1.
  - DONE: one cycle, `done`=1, `busy`=1, `rk_valid`=0; then returns to IDLE.
- IDLE→RUN on `start`=1: load Rows0..4 from `key_in`; set RC=5'h01 and key counter=0.
- Key-state update, applied on each handshake (`rk_valid`&`rk_ready`):
  1. S-box `{6,5,C,A,1,E,7,9,B,0,3,D,8,F,4,2}` on columns 0..3. Column j nibble is `{Row3[j],Row2[j],Row1[j],Row0[j]}`, with Row0 as the LSB.
  2. Row mixing: Row0'=(Row0<<<8)^Row1; Row1'=Row2; Row2'=Row3; Row3'=(Row3<<<12)^Row4; Row4'=Row0. All operands are taken after step 1.
  3. Row0'[4:0] ^= RC.
  4. RC'={RC[3:0], RC[4]^RC[2]}.
- Counter increments on each handshake. A handshake with counter=`NUM_RK`-1 moves RUN→DONE without updating the key state.
- `start` while `busy`=1 is ignored; `key_in` is not resampled.
- `rk_ready` held low stalls indefinitely. `round_key`, `rk_index` and the internal state hold stable; `rk_valid` stays high.
- `rk_ready` outside RUN has no effect.

## Timing
- Reset values: `round_key`=0, `rk_valid`=0, `busy`=0, `done`=0, `rk_index`=0. FSM=IDLE, RC=5'h01.
- Latency: `start` at edge N gives `rk_valid`=1 with K0=`key_in[63:0]` after edge N.
- Throughput: with `rk_ready` tied high, K(i+1) is presented the cycle after K(i) is accepted, so one key per cycle.
- Last handshake at edge M: `done`=1 during the cycle after M. `busy` falls after edge M+1. The earliest new `start` is sampled at edge M+2.
- `rst` during RUN or DONE: the next cycle shows reset values, with no `done` pulse. `rst` has priority over `start` in the same cycle.
- No combinational path from `rk_ready` to any output.

## Configuration
- `RECTANGLE_KS_INDEX_EN` defined: the `rk_index` port exists and equals the counter, updating with `round_key`.
- Undefined: no `rk_index` port. Counter logic is otherwise identical, and all other behaviour is unchanged.

## Structure
- Shared package `rectangle_pkg` holds:
  - S-box as a 16-entry constant array;
  - `RC_INIT`=5'h01;
  - `KEY_W`=80, `RK_W`=64;
  - FSM state enum.
- The datapath stages reuse the same S-box constant.
- One combinational sub-module, `rectangle_sbox4` (4-bit in, 4-bit out), instantiated 4 times for columns 0..3.

## Test plan
- **All-zero key, `rk_ready`=1:** K0=64'h0 one cycle after `start`; K1=64'h0000_0000_000F_000E; 26 consecutive `rk_valid` cycles, then one `done` pulse.
- **Random `rk_ready` back-pressure:** the key sequence is identical to the `rk_ready`=1 run; `round_key` is stable whenever `rk_valid`&!`rk_ready`.
- **Key-sequence check, key 80'hFFFF_FFFF_FFFF_FFFF_FFFF:** all 26 keys match a reference-model sequence; the RC sequence is 01,02,04,09,12,… per the step-4 update.
- **`start` pulsed mid-run with a different key:** ignored; the sequence continues from the original key.
- **`rst` asserted while K10 is presented:** next cycle `rk_valid`=0, `busy`=0, `round_key`=0; a fresh `start` produces K0 correctly.
- **`NUM_RK`=2:** K0, K1, `done`; `busy` low two cycles after the K1 handshake. With `RECTANGLE_KS_INDEX_EN`, `rk_index` reads 0 then 1.
